bubble_sort_ctrl: RTL and testbench
===================================

// Module: bubble_sort_ctrl
// PURPOSE
//   FSM sequencer for the bubble-sort datapath. Walks an N-entry sync-read
//   memory, loads adjacent pairs into the A/B dp_reg pair, and samples the
//   comparator flag gt (A > B). When gt is set it writes the pair back swapped.
//   A pass with no swap ends the sort early. Handshake is start/busy/done.
// PARAMETERS
//   N   8  number of elements to sort; must be >= 2
//   AW  3  memory address width; must satisfy 2**AW >= N
// PORTS
//   clk       in   1   single clock, all state updates on posedge
//   clr_n     in   1   async active-low reset
//   start     in   1   begin sort; sampled only in IDLE
//   gt        in   1   datapath compare: A reg > B reg; valid in CMP
//   busy      out  1   high from INIT through DONE inclusive
//   done      out  1   one-cycle pulse when sort is complete
//   mem_addr  out  AW  memory address
//   mem_re    out  1   read strobe; data returns next cycle
//   mem_we    out  1   write strobe
//   mem_wsel  out  1   write data mux: 1 = B reg, 0 = A reg
//   ld_a      out  1   load enable, A reg (captures mem rdata)
//   ld_b      out  1   load enable, B reg (captures mem rdata)
//   clr_regs  out  1   sync clear of the A and B regs
// BEHAVIOUR
//   Reset (async, clr_n=0): state=IDLE; j=0, p=0, swapped=0; every output 0.
//   Outputs are Moore, decoded from state. Unlisted outputs are 0.
//   States:
//   - IDLE: start=1 -> INIT. Otherwise stay.
//   - INIT: clr_regs=1; j<=0, p<=0, swapped<=0 -> RD_A.
//   - RD_A: mem_addr=j, mem_re=1 -> RD_B.
//   - RD_B: mem_addr=j+1, mem_re=1, ld_a=1 (mem[j] arrives) -> LD_B.
//   - LD_B: ld_b=1 (mem[j+1] arrives) -> CMP.
//   - CMP: sample gt. gt=1 -> SW_A; gt=0 -> NEXT.
//   - SW_A: mem_we=1, mem_addr=j, mem_wsel=1; swapped<=1 -> SW_B.
//   - SW_B: mem_we=1, mem_addr=j+1, mem_wsel=0 -> NEXT.
//   - NEXT, j<N-2-p: j<=j+1 -> RD_A.
//   - NEXT, j==N-2-p, and swapped==0 or p==N-2 -> DONE.
//   - NEXT, j==N-2-p, otherwise: p<=p+1, j<=0, swapped<=0 -> RD_A.
//   - DONE: done=1 -> IDLE.
//   Timing: busy=1 in every state except IDLE.
//   Cost per compare: 5 cycles without a swap, 7 cycles with a swap.
//   Widths: j and p are AW bits. N-2-p never underflows because p <= N-2.
//   start while busy: ignored, no restart or queueing.
//   start held high: a new sort begins one cycle after DONE (IDLE -> INIT).
//   clr_n low mid-sort: immediate return to IDLE with all outputs 0.
//     Memory may be left partially sorted and contents are unspecified.
//     A new start re-sorts from scratch.
//   mem_we and mem_re are never high in the same cycle.
//   mem_addr is 0 when neither strobe is active.
// TESTING
//   1 Reset: clr_n=0 mid-RD_B -> state IDLE at once, all outputs 0;
//     start after release -> normal sort.
//   2 N=4, mem=[1,2,3,4]: one pass, 3 compares, no writes.
//     done pulses in the 17th cycle after start is sampled.
//     mem unchanged, mem_we never high.
//   3 N=4, mem=[4,3,2,1]: 3 passes with 6 swaps -> mem=[1,2,3,4].
//     Exactly 12 mem_we cycles.
//   4 N=8, random values plus duplicates [5,5,0,255,7,7,1,0]
//     -> ascending [0,0,1,5,5,7,7,255]. Equal elements never swap (gt=0).
//   5 start pulsed during CMP and again in the DONE cycle -> both ignored.
//     Exactly one done pulse; busy falls with the DONE->IDLE transition.
//   6 N=2, mem=[9,3]: RD_A,RD_B,LD_B,CMP,SW_A,SW_B,NEXT,DONE -> mem=[3,9].
//     Then start held high: second sort runs with no swaps; mem stays [3,9].

Source files
------------

// File: rtl/bubble_sort_ctrl.sv
// bubble_sort_ctrl: FSM sequencer for a bubble-sort datapath (sync-read memory, A/B regs, A>B comparator).
//   Ports: clk, clr_n (async active-low reset), start (sampled in IDLE), gt (A reg > B reg, valid in CMP);
//   busy (INIT..DONE), done (one-cycle pulse), mem_addr/mem_re/mem_we/mem_wsel (memory control),
//   ld_a/ld_b (A/B reg load enables), clr_regs (sync clear of A/B regs).
module bubble_sort_ctrl #(
   parameter int N  = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          start,
   input  logic          gt,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   output logic          mem_we,
   output logic          mem_wsel,
   output logic          ld_a,
   output logic          ld_b,
   output logic          clr_regs
);
   typedef enum logic [3:0] {IDLE, INIT, RD_A, RD_B, LD_B, CMP, SW_A, SW_B, NEXT, DONE} state_t;
   localparam logic [AW-1:0] LAST = AW'(N - 2);
   state_t state_q, state_d;
   logic [AW-1:0] j_q, j_d, p_q, p_d, j_end;
   logic swapped_q, swapped_d;
   // last left index of the current pass; p never exceeds N-2 so this cannot wrap
   assign j_end = LAST - p_q;
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= IDLE;
         j_q       <= '0;
         p_q       <= '0;
         swapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         j_q       <= j_d;
         p_q       <= p_d;
         swapped_q <= swapped_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      j_d       = j_q;
      p_d       = p_q;
      swapped_d = swapped_q;
      case (state_q)
         IDLE: state_d = start ? INIT : IDLE;
         INIT: begin
            j_d       = '0;
            p_d       = '0;
            swapped_d = 1'b0;
            state_d   = RD_A;
         end
         RD_A: state_d = RD_B;
         RD_B: state_d = LD_B;
         LD_B: state_d = CMP;
         CMP:  state_d = gt ? SW_A : NEXT;
         SW_A: begin
            swapped_d = 1'b1;
            state_d   = SW_B;
         end
         SW_B: state_d = NEXT;
         NEXT: begin
            if (j_q != j_end) begin
               j_d     = j_q + AW'(1);
               state_d = RD_A;
            end else if (!swapped_q || p_q == LAST) begin
               state_d = DONE;
            end else begin
               p_d       = p_q + AW'(1);
               j_d       = '0;
               swapped_d = 1'b0;
               state_d   = RD_A;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // Moore outputs decoded from state; address is 0 whenever no strobe is active
   assign busy     = state_q != IDLE;
   assign done     = state_q == DONE;
   assign mem_re   = state_q == RD_A || state_q == RD_B;
   assign mem_we   = state_q == SW_A || state_q == SW_B;
   assign mem_wsel = state_q == SW_A;
   assign ld_a     = state_q == RD_B;
   assign ld_b     = state_q == LD_B;
   assign clr_regs = state_q == INIT;
   assign mem_addr = (state_q == RD_A || state_q == SW_A) ? j_q :
                     (state_q == RD_B || state_q == SW_B) ? j_q + AW'(1) : '0;
endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// tb_bubble_sort_ctrl: three sequencer instances (N=2,4,8) with memory/A-B datapath models, checked against a sort model.
module tb_bubble_sort_ctrl;
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   logic [2:0] start = '0, ld_en = '0;
   logic [2:0] ld_idx = '0;
   logic [7:0] ld_val = '0;
   logic [2:0] busy, done, re_v, we_v, wsel_v, lda_v, ldb_v, clr_v;
   logic [2:0][2:0] addr_v;
   int checks = 0, errors = 0;
   int vals [8];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : u
      localparam int NN = g == 0 ? 2 : g == 1 ? 4 : 8;
      logic [7:0] mem [8];
      logic [7:0] rdata, ra, rb;
      logic gt;
      assign gt = ra > rb;
      bubble_sort_ctrl #(.N(NN), .AW(3)) dut (
         .clk(clk), .clr_n(clr_n), .start(start[g]), .gt(gt), .busy(busy[g]), .done(done[g]),
         .mem_addr(addr_v[g]), .mem_re(re_v[g]), .mem_we(we_v[g]), .mem_wsel(wsel_v[g]),
         .ld_a(lda_v[g]), .ld_b(ldb_v[g]), .clr_regs(clr_v[g]));
      always_ff @(posedge clk) begin
         if (re_v[g]) rdata <= mem[addr_v[g]];
         if (we_v[g]) mem[addr_v[g]] <= wsel_v[g] ? rb : ra;
         if (ld_en[g]) mem[ld_idx] <= ld_val;
         ra <= clr_v[g] ? 8'd0 : lda_v[g] ? rdata : ra;
         rb <= clr_v[g] ? 8'd0 : ldb_v[g] ? rdata : rb;
      end
   end
   function automatic int rd(int k, int i);
      case (k)
         0: return int'(u[0].mem[i]);
         1: return int'(u[1].mem[i]);
         default: return int'(u[2].mem[i]);
      endcase
   endfunction
   task automatic chk(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic chk_zero(int k);
      chk("outs_zero", int'({busy[k], done[k], re_v[k], we_v[k], wsel_v[k], lda_v[k], ldb_v[k], clr_v[k], addr_v[k]}), 0);
   endtask
   task automatic load(int k, int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ld_en[k] = 1'b1;
         ld_idx = 3'(i);
         ld_val = 8'(vals[i]);
      end
      @(negedge clk);
      ld_en = '0;
   endtask
   // chained: start already high from a held start; pulse: poke start in CMP and DONE; hold: keep start high
   task automatic run(int k, int n, bit chained, bit pulse, bit hold, output int done_at, output int wes);
      int a [8];
      int q [$];
      int cmp, sw, exp_cyc, last, t;
      bit s, prev_ldb;
      cmp = 0;
      sw = 0;
      for (int i = 0; i < n; i++) begin
         a[i] = vals[i];
         q.push_back(vals[i]);
      end
      q.sort();
      for (int p = 0; p <= n - 2; p++) begin
         s = 0;
         for (int j = 0; j <= n - 2 - p; j++) begin
            cmp++;
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
               s = 1;
               sw++;
            end
         end
         if (!s) break;
      end
      exp_cyc = 2 + 5 * cmp + 2 * sw;
      if (!chained) begin
         load(k, n);
         start[k] = 1'b1;
      end
      last = exp_cyc + (pulse ? 3 : 1);
      prev_ldb = 0;
      wes = 0;
      done_at = 0;
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         if (!hold) start[k] = 1'b0;
         chk("done", int'(done[k]), int'(c == exp_cyc));
         chk("busy", int'(busy[k]), int'(c <= exp_cyc));
         chk("re_we_excl", int'(re_v[k] & we_v[k]), 0);
         chk("addr_idle", (!re_v[k] && !we_v[k]) ? int'(addr_v[k]) : 0, 0);
         if (done[k] && done_at == 0) done_at = c;
         wes += int'(we_v[k]);
         if (pulse && (prev_ldb || c == exp_cyc)) start[k] = 1'b1;
         prev_ldb = ldb_v[k];
      end
      chk("we_count", wes, 2 * sw);
      for (int i = 0; i < n; i++) chk("mem", rd(k, i), q[i]);
      for (int i = 0; i < n; i++) vals[i] = q[i];
   endtask
   initial begin
      int da, wc;
      bit found;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) chk_zero(k);
      clr_n = 1'b1;
      // reset mid-RD_B, then a clean sort
      vals = '{6, 2, 7, 1, 9, 0, 3, 4};
      load(2, 8);
      start[2] = 1'b1;
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         start[2] = 1'b0;
         found = re_v[2] && lda_v[2];
      end
      chk("reach_rd_b", int'(found), 1);
      clr_n = 1'b0;
      #1;
      chk_zero(2);
      @(negedge clk);
      chk_zero(2);
      clr_n = 1'b1;
      run(2, 8, 0, 0, 0, da, wc);
      // already sorted N=4
      vals = '{1, 2, 3, 4, 0, 0, 0, 0};
      run(1, 4, 0, 0, 0, da, wc);
      chk("t2_done_cycle", da, 17);
      chk("t2_no_writes", wc, 0);
      // reversed N=4
      vals = '{4, 3, 2, 1, 0, 0, 0, 0};
      run(1, 4, 0, 0, 0, da, wc);
      chk("t3_we_cycles", wc, 12);
      // duplicates N=8
      vals = '{5, 5, 0, 255, 7, 7, 1, 0};
      run(2, 8, 0, 0, 0, da, wc);
      chk("t4_first", rd(2, 0), 0);
      chk("t4_last", rd(2, 7), 255);
      // random N=8 with likely duplicates, random N=4 with start pokes in CMP and DONE
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) vals[i] = int'($urandom_range(0, 15));
         run(2, 8, 0, 0, 0, da, wc);
         for (int i = 0; i < 4; i++) vals[i] = int'($urandom_range(0, 255));
         run(1, 4, 0, 1, 0, da, wc);
      end
      // N=2 swap, then start held high restarts a no-swap sort
      vals = '{9, 3, 0, 0, 0, 0, 0, 0};
      run(0, 2, 0, 0, 1, da, wc);
      chk("t6_done_cycle", da, 9);
      chk("t6_m0", rd(0, 0), 3);
      chk("t6_m1", rd(0, 1), 9);
      run(0, 2, 1, 0, 0, da, wc);
      chk("t6_rerun_cycle", da, 7);
      chk("t6_rerun_writes", wc, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
